// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register bank: frame layout, register
// addresses and the receive FSM state type.
package spi_reg_pkg;

  // 16-bit frame: bit15 R/W (1 = write), bits14:8 address, bits7:0 data.
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned RW_BIT     = 15;
  localparam int unsigned ADDR_MSB   = 14;
  localparam int unsigned ADDR_LSB   = 8;
  localparam int unsigned DATA_MSB   = 7;
  localparam int unsigned DATA_LSB   = 0;
  localparam int unsigned ADDR_W     = ADDR_MSB - ADDR_LSB + 1;
  localparam int unsigned DATA_W     = DATA_MSB - DATA_LSB + 1;

  // Bit counter counts to FRAME_BITS+1, which marks an overrun frame.
  localparam int unsigned CNT_W      = 5;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_DUTY      = 7'h04;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_e;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchroniser for one asynchronous pin, with registered edge
// pulses.
//   clk, rst  : system clock, synchronous active-high reset
//   pin_i     : asynchronous input pin
//   level_o   : synchronised level (aligned with the edge pulses)
//   rise_o    : one-cycle pulse on a synchronised rising edge
//   fall_o    : one-cycle pulse on a synchronised falling edge
module spi_input_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_q;
  logic                   rise_q;
  logic                   fall_q;

  // level_q is the extra flop used for edge detection; the pulses are
  // registered so they line up with level_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= {SYNC_STAGES{RST_VAL}};
      level_q <= RST_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pin_i};
      level_q <= sync_q[SYNC_STAGES-1];
      rise_q  <= sync_q[SYNC_STAGES-1] & ~level_q;
      fall_q  <= ~sync_q[SYNC_STAGES-1] & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/spi_register_bank.sv
// Write-only SPI (mode 0) slave feeding the PWM peripheral's control
// registers. Pins are synchronised into clk, 16-bit frames are shifted in
// MSB-first and committed to the register bank on nCS rising.
//   clk, rst            : system clock, synchronous active-high reset
//   SCLK, COPI, nCS     : asynchronous SPI pins
//   en_reg_out_7_0 ..   : register contents, addresses 0x00..0x04
//   pwm_duty_cycle
//   wr_strobe, wr_addr  : one-cycle pulse and address of each committed write
//   frame_err           : one-cycle pulse when a frame is rejected
module spi_register_bank
  import spi_reg_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCLK,
  input  logic              COPI,
  input  logic              nCS,
  output logic [7:0]        en_reg_out_7_0,
  output logic [7:0]        en_reg_out_15_8,
  output logic [7:0]        en_reg_pwm_7_0,
  output logic [7:0]        en_reg_pwm_15_8,
  output logic [7:0]        pwm_duty_cycle,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              frame_err
);

  localparam int unsigned REG_SLOTS = (NUM_REGS > 5) ? NUM_REGS : 5;
  localparam int unsigned IDX_W     = $clog2(REG_SLOTS);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);
  localparam int unsigned SETTLE    = SYNC_STAGES + 2;
  localparam int unsigned SETTLE_W  = $clog2(SETTLE + 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic copi_lvl, copi_rise, copi_fall;
  logic ncs_lvl, ncs_rise_raw, ncs_fall_raw;

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .pin_i(SCLK),
    .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi_sync (
    .clk(clk), .rst(rst), .pin_i(COPI),
    .level_o(copi_lvl), .rise_o(copi_rise), .fall_o(copi_fall)
  );

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs_sync (
    .clk(clk), .rst(rst), .pin_i(nCS),
    .level_o(ncs_lvl), .rise_o(ncs_rise_raw), .fall_o(ncs_fall_raw)
  );

  // Only the SCLK rise and nCS edges drive the FSM.
  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, sclk_fall, copi_rise, copi_fall, ncs_lvl};

  // The nCS synchroniser resets to 1, so a pin held low across reset release
  // would look like a falling edge. nCS edges are ignored until the
  // synchroniser has filled with real pin values.
  logic [SETTLE_W-1:0] settle_q;
  logic                settled;
  logic                ncs_rise, ncs_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      settle_q <= '0;
    end else if (!settled) begin
      settle_q <= settle_q + 1'b1;
    end
  end

  assign settled  = (settle_q == SETTLE_W'(SETTLE));
  assign ncs_rise = ncs_rise_raw & settled;
  assign ncs_fall = ncs_fall_raw & settled;

  state_e                state_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [DATA_W-1:0]     regs_q [REG_SLOTS];
  logic                  wr_strobe_q;
  logic [ADDR_W-1:0]     wr_addr_q;
  logic                  frame_err_q;

  logic [ADDR_W-1:0] frame_addr_d;
  logic [DATA_W-1:0] frame_data_d;
  logic              frame_wr_d;
  logic              len_ok_d;
  logic              addr_ok_d;

  always_comb begin
    frame_addr_d = shift_q[ADDR_MSB:ADDR_LSB];
    frame_data_d = shift_q[DATA_MSB:DATA_LSB];
    frame_wr_d   = shift_q[RW_BIT];
    len_ok_d     = (bit_cnt_q == CNT_FULL);
    addr_ok_d    = (32'(frame_addr_d) < NUM_REGS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
      for (int unsigned i = 0; i < REG_SLOTS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (ncs_fall) begin
            state_q   <= SHIFT;
            bit_cnt_q <= '0;
            shift_q   <= '0;
          end
        end
        SHIFT: begin
          // nCS rising wins over a coincident SCLK edge.
          if (ncs_rise) begin
            state_q <= COMMIT;
          end else if (sclk_rise) begin
            shift_q <= {shift_q[FRAME_BITS-2:0], copi_lvl};
            if (bit_cnt_q != CNT_SAT) begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        COMMIT: begin
          state_q <= IDLE;
          if (!len_ok_d) begin
            frame_err_q <= 1'b1;
          end else if (frame_wr_d) begin
            if (addr_ok_d) begin
              regs_q[frame_addr_d[IDX_W-1:0]] <= frame_data_d;
              wr_strobe_q <= 1'b1;
              wr_addr_q   <= frame_addr_d;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_LO[IDX_W-1:0]];
  assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_HI[IDX_W-1:0]];
  assign en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_LO[IDX_W-1:0]];
  assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_HI[IDX_W-1:0]];
  assign pwm_duty_cycle  = regs_q[ADDR_DUTY[IDX_W-1:0]];
  assign wr_strobe       = wr_strobe_q;
  assign wr_addr         = wr_addr_q;
  assign frame_err       = frame_err_q;

endmodule
